// File: rtl/param_fifo.sv
// rtl/param_fifo.sv - parametrised single-clock FIFO with show-ahead, thresholds, occupancy and error pulses
module param_fifo #(
    parameter int width              = 8,
    parameter int widthu             = 3,
    parameter int showahead          = 0,
    parameter int almost_full_value  = 6,
    parameter int almost_empty_value = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclr,
    input  logic              wrreq,
    input  logic [width-1:0]  data,
    input  logic              rdreq,
    output logic [width-1:0]  q,
    output logic              empty,
    output logic              full,
    output logic              almost_empty,
    output logic              almost_full,
    output logic [widthu:0]   usedw,
    output logic              overflow,
    output logic              underflow
);

    localparam int                DEPTH    = 2 ** widthu;
    localparam logic [widthu:0]   DEPTH_W  = (widthu + 1)'(DEPTH);
    localparam logic [widthu:0]   AF_W     = (widthu + 1)'(almost_full_value);
    localparam logic [widthu:0]   AE_W     = (widthu + 1)'(almost_empty_value);
    localparam logic [widthu:0]   CNT_ONE  = (widthu + 1)'(1);
    localparam logic [widthu-1:0] PTR_ONE  = widthu'(1);

    logic [width-1:0]  mem [DEPTH];
    logic [widthu-1:0] wr_ptr;
    logic [widthu-1:0] rd_ptr;
    logic [widthu:0]   count;
    logic              clr;
    logic              wr_acc;
    logic              rd_acc;

    assign clr    = rst || sclr;
    // Acceptance uses registered flags only, so full blocks write-through and empty blocks bypass.
    assign wr_acc = wrreq && !full;
    assign rd_acc = rdreq && !empty;

    assign usedw        = count;
    assign empty        = (count == '0);
    assign full         = (count == DEPTH_W);
    assign almost_full  = (count >= AF_W);
    assign almost_empty = (count < AE_W);

    always_ff @(posedge clk) begin
        if (!clr && wr_acc) begin
            mem[wr_ptr] <= data;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= wrreq && full;
            underflow <= rdreq && empty;
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    generate
        if (showahead != 0) begin : g_showahead
            assign q = mem[rd_ptr];
        end else begin : g_normal
            always_ff @(posedge clk) begin
                if (clr) begin
                    q <= '0;
                end else if (rd_acc) begin
                    q <= mem[rd_ptr];
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_param_fifo.sv
// tb/tb_param_fifo.sv - scoreboard bench driving a normal-mode and a show-ahead param_fifo in lockstep
module tb_param_fifo;

    logic       clk = 1'b0;
    logic       rst, sclr, wrreq, rdreq;
    logic [7:0] data;

    logic [7:0] q_n, q_s;
    logic       empty_n, full_n, ae_n, af_n, ovf_n, unf_n;
    logic       empty_s, full_s, ae_s, af_s, ovf_s, unf_s;
    logic [3:0] usedw_n, usedw_s;

    always #5 clk = ~clk;

    param_fifo #(.width(8), .widthu(3), .showahead(0), .almost_full_value(6), .almost_empty_value(2)) dut_n (
        .clk(clk), .rst(rst), .sclr(sclr), .wrreq(wrreq), .data(data), .rdreq(rdreq),
        .q(q_n), .empty(empty_n), .full(full_n), .almost_empty(ae_n), .almost_full(af_n),
        .usedw(usedw_n), .overflow(ovf_n), .underflow(unf_n)
    );

    param_fifo #(.width(8), .widthu(3), .showahead(1), .almost_full_value(6), .almost_empty_value(2)) dut_s (
        .clk(clk), .rst(rst), .sclr(sclr), .wrreq(wrreq), .data(data), .rdreq(rdreq),
        .q(q_s), .empty(empty_s), .full(full_s), .almost_empty(ae_s), .almost_full(af_s),
        .usedw(usedw_s), .overflow(ovf_s), .underflow(unf_s)
    );

    typedef struct {
        string      name;
        logic [7:0] q_n;
        logic [7:0] q_s;
        logic       q_s_chk;
        logic [3:0] usedw;
        logic       empty, full, ae, af, ovf, unf;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] mq[$];
    logic [7:0] m_qn;
    logic       m_ovf, m_unf;
    int         checks   = 0;
    int         failures = 0;

    task automatic chk(input string nm, input string field, input logic [8:0] act, input logic [8:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s.%s got=%0h expected=%0h", nm, field, act, expv);
        end
    endtask

    // Monitor: every cycle the DUTs present a new state, compare it against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk(e.name, "n.q",     {1'b0, q_n},     {1'b0, e.q_n});
                chk(e.name, "n.usedw", {5'b0, usedw_n}, {5'b0, e.usedw});
                chk(e.name, "n.empty", {8'b0, empty_n}, {8'b0, e.empty});
                chk(e.name, "n.full",  {8'b0, full_n},  {8'b0, e.full});
                chk(e.name, "n.aempty",{8'b0, ae_n},    {8'b0, e.ae});
                chk(e.name, "n.afull", {8'b0, af_n},    {8'b0, e.af});
                chk(e.name, "n.ovf",   {8'b0, ovf_n},   {8'b0, e.ovf});
                chk(e.name, "n.unf",   {8'b0, unf_n},   {8'b0, e.unf});
                if (e.q_s_chk) chk(e.name, "s.q", {1'b0, q_s}, {1'b0, e.q_s});
                chk(e.name, "s.usedw", {5'b0, usedw_s}, {5'b0, e.usedw});
                chk(e.name, "s.empty", {8'b0, empty_s}, {8'b0, e.empty});
                chk(e.name, "s.full",  {8'b0, full_s},  {8'b0, e.full});
                chk(e.name, "s.aempty",{8'b0, ae_s},    {8'b0, e.ae});
                chk(e.name, "s.afull", {8'b0, af_s},    {8'b0, e.af});
                chk(e.name, "s.ovf",   {8'b0, ovf_s},   {8'b0, e.ovf});
                chk(e.name, "s.unf",   {8'b0, unf_s},   {8'b0, e.unf});
            end
        end
    end

    // One clock of stimulus; the queue model yields the expected state after the edge.
    task automatic step(input string nm, input logic rs, input logic sc,
                        input logic w, input logic [7:0] d, input logic r);
        exp_t e;
        logic wacc, racc;
        rst = rs; sclr = sc; wrreq = w; data = d; rdreq = r;
        @(posedge clk);
        if (rs || sc) begin
            mq.delete();
            m_qn = 8'h00; m_ovf = 1'b0; m_unf = 1'b0;
        end else begin
            wacc  = w && (mq.size() < 8);
            racc  = r && (mq.size() > 0);
            m_ovf = w && !wacc;
            m_unf = r && !racc;
            if (racc) m_qn = mq.pop_front();
            if (wacc) mq.push_back(d);
        end
        e.name    = nm;
        e.q_n     = m_qn;
        e.q_s_chk = (mq.size() > 0);
        e.q_s     = (mq.size() > 0) ? mq[0] : 8'h00;
        e.usedw   = 4'(mq.size());
        e.empty   = (mq.size() == 0);
        e.full    = (mq.size() == 8);
        e.ae      = (mq.size() < 2);
        e.af      = (mq.size() >= 6);
        e.ovf     = m_ovf;
        e.unf     = m_unf;
        exp_q.push_back(e);
        @(negedge clk);
        rst = 1'b0; sclr = 1'b0; wrreq = 1'b0; rdreq = 1'b0;
    endtask

    initial begin
        m_qn = 8'h00; m_ovf = 1'b0; m_unf = 1'b0;
        step("reset0", 1, 0, 1, 8'h33, 1);
        step("reset1", 1, 0, 0, 8'h00, 0);
        for (int i = 1; i <= 8; i++) step($sformatf("fill%0d", i), 0, 0, 1, 8'(i), 0);
        step("ovf_full", 0, 0, 1, 8'hFF, 0);
        step("ovf_clear", 0, 0, 0, 8'h00, 0);
        for (int i = 1; i <= 8; i++) step($sformatf("drain%0d", i), 0, 0, 0, 8'h00, 1);
        step("unf_a", 0, 0, 0, 8'h00, 1);
        step("unf_b", 0, 0, 0, 8'h00, 1);
        step("wr_rd_empty", 0, 0, 1, 8'h50, 1);
        for (int i = 1; i <= 3; i++) step($sformatf("half%0d", i), 0, 0, 1, 8'(8'h50 + i), 0);
        for (int i = 0; i < 20; i++) step($sformatf("stream%0d", i), 0, 0, 1, 8'(8'h60 + i), 1);
        for (int i = 0; i < 4; i++) step($sformatf("tail%0d", i), 0, 0, 0, 8'h00, 1);
        step("sa_wr_aa", 0, 0, 1, 8'hAA, 0);
        step("sa_idle", 0, 0, 0, 8'h00, 0);
        step("sa_wr_bb", 0, 0, 1, 8'hBB, 0);
        step("sa_rd1", 0, 0, 0, 8'h00, 1);
        step("sa_rd2", 0, 0, 0, 8'h00, 1);
        for (int i = 0; i < 5; i++) step($sformatf("pre_sclr%0d", i), 0, 0, 1, 8'(8'hC0 + i), 0);
        step("sclr_wr", 0, 1, 1, 8'hCF, 0);
        step("post_sclr", 0, 0, 0, 8'h00, 1);
        for (int i = 0; i < 3; i++) step($sformatf("pre_rst%0d", i), 0, 0, 1, 8'(8'hD0 + i), 1);
        step("rst_mid", 1, 0, 1, 8'hDF, 1);
        step("post_rst", 0, 0, 0, 8'h00, 0);
        for (int i = 0; i < 8; i++) step($sformatf("refill%0d", i), 0, 0, 1, 8'(8'h10 + i), 0);
        step("full_wr_rd", 0, 0, 1, 8'hEE, 1);
        step("after_full_wr_rd", 0, 0, 0, 8'h00, 1);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
